bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 112 +++++++++++
 tb/tb_bus_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: three-way round-robin bus arbiter with hold timeout and drain gap.
// Gives one requester at a time ownership of the shared buses.
module bus_arbiter #(
    parameter int MAX_HOLD     = 16,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic       reset,
    input  logic       ctrl_clk,
    input  logic [2:0] req,
    input  logic [2:0] done,
    output logic [2:0] grant,
    output logic [1:0] owner,
    output logic       control_enable,
    output logic       timeout,
    output logic [1:0] timeout_id,
    output logic       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWNED = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] owner_q, owner_d;
    logic       timeout_q, timeout_d;
    logic [1:0] timeout_id_q, timeout_id_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic [1:0] win;
    logic [2:0] idx;
    logic       rel;

    // Scan from the highest offset down so the first set bit after rr_ptr wins.
    always_comb begin
        win = 2'd0;
        idx = 3'd0;
        for (int i = 2; i >= 0; i--) begin
            idx = {1'b0, rr_ptr_q} + 3'(i);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (req[idx[1:0]]) win = idx[1:0];
        end
    end

    assign rel = done[owner_q] || !req[owner_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;
        rr_ptr_d     = rr_ptr_q;
        hold_cnt_d   = hold_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d    = OWNED;
                grant_d    = 3'b001 << win;
                owner_d    = win;
                hold_cnt_d = 8'd0;
                rr_ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
            end
            OWNED: begin
                hold_cnt_d = hold_cnt_q + 8'd1;
                // A voluntary release takes priority over the hold limit.
                if (rel || hold_cnt_q == 8'(MAX_HOLD - 1)) begin
                    state_d      = DRAIN;
                    grant_d      = 3'b000;
                    owner_d      = 2'd3;
                    drain_cnt_d  = 2'd0;
                    timeout_d    = !rel;
                    timeout_id_d = rel ? timeout_id_q : owner_q;
                end
            end
            DRAIN: begin
                state_d     = (drain_cnt_q == 2'(DRAIN_CYCLES - 1)) ? IDLE : DRAIN;
                drain_cnt_d = drain_cnt_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ctrl_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 3'b000;
            owner_q      <= 2'd3;
            timeout_q    <= 1'b0;
            timeout_id_q <= 2'd0;
            rr_ptr_q     <= 2'd0;
            hold_cnt_q   <= 8'd0;
            drain_cnt_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    assign grant          = grant_q;
    assign owner          = owner_q;
    assign control_enable = grant_q[0];
    assign timeout        = timeout_q;
    assign timeout_id     = timeout_id_q;
    assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors for bus_arbiter with hand-computed expectations.
module tb_bus_arbiter;
    logic       reset = 1'b1;
    logic       ctrl_clk = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] done = 3'b000;
    logic [2:0] grant;
    logic [1:0] owner;
    logic       control_enable;
    logic       timeout;
    logic [1:0] timeout_id;
    logic       busy;
    int         n_tests = 0;
    int         n_fail = 0;

    bus_arbiter dut (
        .reset(reset), .ctrl_clk(ctrl_clk), .req(req), .done(done),
        .grant(grant), .owner(owner), .control_enable(control_enable),
        .timeout(timeout), .timeout_id(timeout_id), .busy(busy)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ctrl_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 3'b000;
        done  = 3'b000;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_owner", 32'(owner), 32'h3);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] exp;
        do_reset();
        chk("rst_ce", 32'(control_enable), 32'h0);
        chk("rst_to", 32'(timeout), 32'h0);
        chk("rst_tid", 32'(timeout_id), 32'h0);

        req = 3'b001;
        tick();
        chk("a_grant", 32'(grant), 32'h1);
        chk("a_owner", 32'(owner), 32'h0);
        chk("a_ce", 32'(control_enable), 32'h1);
        chk("a_busy", 32'(busy), 32'h1);
        tick(); tick(); tick();
        chk("a_hold", 32'(grant), 32'h1);
        done = 3'b001;
        tick();
        chk("a_rel_grant", 32'(grant), 32'h0);
        chk("a_rel_owner", 32'(owner), 32'h3);
        chk("a_drain_busy", 32'(busy), 32'h1);
        chk("a_no_to", 32'(timeout), 32'h0);
        done = 3'b000;
        req  = 3'b000;
        tick();
        chk("a_idle_busy", 32'(busy), 32'h0);

        do_reset();
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            exp = 3'b001 << (k % 3);
            tick();
            chk("rr_grant", 32'(grant), 32'(exp));
            chk("rr_ce", 32'(control_enable), 32'(exp[0]));
            tick();
            chk("rr_hold", 32'(grant), 32'(exp));
            done = exp;
            tick();
            chk("rr_gap1", 32'(grant), 32'h0);
            done = 3'b000;
            tick();
            chk("rr_gap2", 32'(grant), 32'h0);
        end
        req = 3'b000;

        do_reset();
        req = 3'b010;
        tick();
        chk("to_grant", 32'(grant), 32'h2);
        for (int c = 1; c < 16; c++) begin
            tick();
            chk("to_held", 32'(grant), 32'h2);
            chk("to_quiet", 32'(timeout), 32'h0);
        end
        tick();
        chk("to_rel", 32'(grant), 32'h0);
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_id", 32'(timeout_id), 32'h1);
        chk("to_owner", 32'(owner), 32'h3);
        tick();
        chk("to_one_cycle", 32'(timeout), 32'h0);
        chk("to_id_hold", 32'(timeout_id), 32'h1);
        req = 3'b000;
        tick();
        chk("to_idle", 32'(grant), 32'h0);

        req = 3'b010;
        tick();
        chk("dw_grant", 32'(grant), 32'h2);
        for (int c = 1; c < 16; c++) tick();
        chk("dw_held", 32'(grant), 32'h2);
        done = 3'b010;
        tick();
        chk("dw_rel", 32'(grant), 32'h0);
        chk("dw_no_to", 32'(timeout), 32'h0);
        done = 3'b000;
        req  = 3'b000;
        tick();
        req = 3'b001;
        tick();
        chk("nd_grant", 32'(grant), 32'h1);
        done = 3'b100;
        tick();
        chk("nd_ign2", 32'(grant), 32'h1);
        done = 3'b010;
        tick();
        chk("nd_ign1", 32'(grant), 32'h1);
        done = 3'b000;
        req  = 3'b000;
        tick();
        tick();

        do_reset();
        req = 3'b100;
        tick();
        chk("ar_grant", 32'(grant), 32'h4);
        tick();
        reset = 1'b1;
        #1;
        chk("ar_grant0", 32'(grant), 32'h0);
        chk("ar_owner", 32'(owner), 32'h3);
        chk("ar_busy", 32'(busy), 32'h0);
        req = 3'b110;
        tick();
        reset = 1'b0;
        tick();
        chk("ar_rr0", 32'(grant), 32'h2);
        chk("ar_owner1", 32'(owner), 32'h1);

        req = 3'b100;
        tick();
        chk("dr_rel", 32'(grant), 32'h0);
        chk("dr_no_to", 32'(timeout), 32'h0);
        chk("dr_owner", 32'(owner), 32'h3);
        tick();
        chk("dr_drain", 32'(grant), 32'h0);
        tick();
        chk("dr_next", 32'(grant), 32'h4);
        chk("dr_ce", 32'(control_enable), 32'h0);
        req = 3'b000;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
